sram_word_master: RTL and testbench
===================================

Name: sram_word_master

Overview:
- Initiator side of the 16-bit asynchronous SRAM bus that the core shares with the Ram model (addr[17:0], bidirectional data[15:0], wre, oute, hb_mask, lb_mask, chip_en).
- Accepts 32-bit word read/write requests from the core's fetch/load-store path.
- Sequences each request as two 16-bit SRAM half-accesses with programmable strobe width, then returns one acknowledge.

Parameters:
- WAIT_CYCLES, 1, strobe (wre/oute low) duration per half-access, in clocks; legal range 1..15.
- ADDR_W, 18, SRAM halfword address width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  core request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- byte_addr  input  32  byte address; bits [1:0] ignored; bits [31:19] ignored (aliased).
- wdata  input  32  write data, little-endian.
- be  input  4  byte enables for writes; ignored for reads.
- rdata  output  32  read data; valid while ack=1, held until the next read completes.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from request acceptance to the cycle of ack, inclusive.
- addr  output  ADDR_W  SRAM halfword address.
- data  inout  16  SRAM data; driven only during write half-accesses, otherwise high-Z.
- wre  output  1  write enable, active-low.
- oute  output  1  output enable, active-low.
- hb_mask  output  1  upper-byte select, active-low.
- lb_mask  output  1  lower-byte select, active-low.
- chip_en  output  1  chip enable, active-low.

Behaviour:
- Reset (async, reset=0): state IDLE.
  - wre, oute, chip_en, hb_mask, lb_mask = 1; addr = 0; data = Z.
  - ack, busy = 0; rdata = 0.
  - Reset mid-transfer aborts immediately; no partial ack.
- Halfword mapping:
  - Low half (wdata/rdata [15:0]) at SRAM address {byte_addr[18:2],1'b0}.
  - High half ([31:16]) at {byte_addr[18:2],1'b1}.
  - Low half is always accessed first.
- Half masks:
  - Reads: hb_mask = lb_mask = 0 on both halves.
  - Writes, low half: lb_mask = ~be[0], hb_mask = ~be[1].
  - Writes, high half: lb_mask = ~be[2], hb_mask = ~be[3].
  - A write half whose two enables are both 0 is skipped entirely (no SRAM cycle).
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. Half-select flag h selects low (0) or high (1).
  - IDLE: on req=1, latch we/addr/wdata/be and set busy.
    - If the write has be=4'b0000, go directly to DONE.
    - Otherwise set h to the first non-skipped half and go to SETUP.
  - SETUP (1 cycle): chip_en=0, addr valid, masks valid, wre=oute=1. Writes drive data.
  - STROBE (WAIT_CYCLES cycles, counter-timed): write drops wre=0; read drops oute=0. The read samples data at the last STROBE edge into the rdata half.
  - HOLD (1 cycle): strobes high. Addr, masks, chip_en and write data are held.
    - If h=0 and the high half is required, set h=1 and go to SETUP.
    - Otherwise go to DONE.
  - DONE (1 cycle): ack=1, chip_en=1, data=Z, busy=1; next state IDLE.
    - busy falls the following cycle.
    - A req already high in the DONE cycle is accepted the cycle after, in IDLE.
- Latency, from the req-sampled edge to the ack cycle:
  - Full read or two-half write: 2*(WAIT_CYCLES+2)+1 clocks (7 at default).
  - Single-half write: WAIT_CYCLES+3 clocks (4).
  - be=0 write: 1 clock.
- Bus discipline:
  - wre and oute are never low simultaneously.
  - data is never driven while oute=0.
  - Address/mask changes occur only with both strobes high.
- req while busy is ignored; no queueing.
- rdata updates only on read completion; writes leave it unchanged.

Decomposition:
- Shared package mips_mem_pkg holds:
  - FSM state enum;
  - SRAM active-low constants (SRAM_ASSERT=0, SRAM_DEASSERT=1);
  - halfword-address helper function;
  - WAIT_CYCLES legal bounds.
- One natural sub-module: sram_strobe_timer (loadable down-counter with done flag), reused for STROBE timing.

Test Plan:
- Read at byte_addr 0x0000_0010, RAM[8]=0x1234, RAM[9]=0xABCD -> addr 8 then 9, oute pulses 1 cycle each, ack at cycle 7, rdata=0xABCD1234.
- Write 0xDEADBEEF, be=4'hF, byte_addr 0x20 -> RAM[16]=0xBEEF, RAM[17]=0xDEAD, masks 0, data Z outside write halves, ack at cycle 7.
- Write be=4'b0100, wdata=0x00770000 at 0x20 -> only addr 17 accessed, lb_mask=0, hb_mask=1, RAM[17] low byte=0x77, high byte unchanged, ack at cycle 4; be=0 -> ack at cycle 1, chip_en stays 1.
- WAIT_CYCLES=3 read -> oute low 3 consecutive cycles per half, ack at cycle 11; a req pulse during busy produces no extra access.
- reset=0 asserted during STROBE of a write -> wre/chip_en return 1 and data goes Z asynchronously, no ack; a subsequent read completes normally.
- Back-to-back reads with req held high -> second request accepted the cycle after DONE, oute never overlaps wre across the whole run.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the 16-bit asynchronous SRAM initiator.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } sram_state_t;

    localparam logic SRAM_ASSERT   = 1'b0;
    localparam logic SRAM_DEASSERT = 1'b1;

    localparam int SRAM_ADDR_W = 18;
    localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;
    localparam int WAIT_MIN    = 1;
    localparam int WAIT_MAX    = 15;

    // Word index plus half-select gives the SRAM halfword address.
    function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [WORD_IDX_W-1:0] word_idx,
                                                         input logic hi);
        return {word_idx, hi};
    endfunction

    // Timer load value for a strobe of w clocks, clamped to the legal range.
    function automatic logic [3:0] wait_load(input int w);
        if (w < WAIT_MIN) return 4'd0;
        if (w > WAIT_MAX) return 4'(WAIT_MAX - 1);
        return 4'(w - 1);
    endfunction

endpackage

// File: rtl/sram_strobe_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Latency: load takes effect on the next edge; one decrement per enabled clock.
// Backpressure: none; counter holds at zero until reloaded.
module sram_strobe_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sram_word_master.sv
// 32-bit word requests sequenced as two 16-bit asynchronous SRAM half-accesses.
// Latency: 2*(WAIT_CYCLES+2)+1 full word, WAIT_CYCLES+3 single-half write, 1 for be=0 write.
// Backpressure: busy from acceptance through ack; req while busy is dropped, not queued.
module sram_word_master
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       byte_addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [15:0]       data,
    output logic              wre,
    output logic              oute,
    output logic              hb_mask,
    output logic              lb_mask,
    output logic              chip_en
);

    sram_state_t           state_q, state_d;
    logic                  we_q;
    logic [WORD_IDX_W-1:0] word_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  h_q;
    logic [15:0]           rbuf_lo_q, rbuf_hi_q;
    logic [31:0]           rdata_q;
    logic                  timer_done;
    logic                  hi_need;
    logic [1:0]            half_be;
    logic                  drive_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{byte_addr[31:19], byte_addr[1:0]};
    assign hi_need = !we_q || (be_q[3:2] != 2'b00);
    assign half_be = h_q ? be_q[3:2] : be_q[1:0];

    sram_strobe_timer #(.CNT_W(4)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (state_q == ST_SETUP),
        .load_val (wait_load(WAIT_CYCLES)),
        .en       (state_q == ST_STROBE),
        .done     (timer_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (req) state_d = (we && be == 4'b0000) ? ST_DONE : ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: if (timer_done) state_d = ST_HOLD;
            ST_HOLD:   state_d = (!h_q && hi_need) ? ST_SETUP : ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Read halves are staged so rdata only moves when the whole word is in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q      <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            h_q       <= 1'b0;
            rbuf_lo_q <= '0;
            rbuf_hi_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && req) begin
                we_q    <= we;
                word_q  <= byte_addr[18:2];
                wdata_q <= wdata;
                be_q    <= be;
                h_q     <= we && (be[1:0] == 2'b00);
            end
            if (state_q == ST_HOLD && !h_q && hi_need) begin
                h_q <= 1'b1;
            end
            if (state_q == ST_STROBE && timer_done && !we_q) begin
                if (h_q) rbuf_hi_q <= data;
                else     rbuf_lo_q <= data;
            end
            if (state_q == ST_HOLD && state_d == ST_DONE && !we_q) begin
                rdata_q <= {rbuf_hi_q, rbuf_lo_q};
            end
        end
    end

    always_comb begin
        wre        = SRAM_DEASSERT;
        oute       = SRAM_DEASSERT;
        chip_en    = SRAM_DEASSERT;
        hb_mask    = SRAM_DEASSERT;
        lb_mask    = SRAM_DEASSERT;
        drive_data = 1'b0;
        case (state_q)
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                chip_en = SRAM_ASSERT;
                if (we_q) begin
                    lb_mask    = ~half_be[0];
                    hb_mask    = ~half_be[1];
                    drive_data = 1'b1;
                end else begin
                    lb_mask = SRAM_ASSERT;
                    hb_mask = SRAM_ASSERT;
                end
                if (state_q == ST_STROBE) begin
                    if (we_q) wre  = SRAM_ASSERT;
                    else      oute = SRAM_ASSERT;
                end
            end
            default: ;
        endcase
    end

    assign data  = drive_data ? (h_q ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
    assign addr  = ADDR_W'(half_addr(word_q, h_q));
    assign rdata = rdata_q;
    assign ack   = (state_q == ST_DONE);
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_word_master.sv
// Two initiators (WAIT_CYCLES 1 and 3) on private SRAM buses backed by one memory image.
// Each word transfer is compared against a word-level model of latency, bus activity and memory.
module tb_sram_word_master;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]        req_w, we_w, ack_w, busy_w, wre_w, oute_w, hb_w, lb_w, ce_w;
    logic [1:0][31:0]  ba_w, wd_w, rdata_w;
    logic [1:0][3:0]   be_w;
    logic [1:0][17:0]  addr_w;
    wire  [15:0]       data0, data1;

    logic [15:0] mem     [0:262143];
    logic [15:0] ref_mem [0:262143];
    logic [1:0][31:0] exp_rd;

    int total = 0;
    int bad   = 0;

    sram_word_master #(.WAIT_CYCLES(1), .ADDR_W(18)) u_dut0 (
        .clock(clock), .reset(reset), .req(req_w[0]), .we(we_w[0]), .byte_addr(ba_w[0]),
        .wdata(wd_w[0]), .be(be_w[0]), .rdata(rdata_w[0]), .ack(ack_w[0]), .busy(busy_w[0]),
        .addr(addr_w[0]), .data(data0), .wre(wre_w[0]), .oute(oute_w[0]),
        .hb_mask(hb_w[0]), .lb_mask(lb_w[0]), .chip_en(ce_w[0])
    );

    sram_word_master #(.WAIT_CYCLES(3), .ADDR_W(18)) u_dut1 (
        .clock(clock), .reset(reset), .req(req_w[1]), .we(we_w[1]), .byte_addr(ba_w[1]),
        .wdata(wd_w[1]), .be(be_w[1]), .rdata(rdata_w[1]), .ack(ack_w[1]), .busy(busy_w[1]),
        .addr(addr_w[1]), .data(data1), .wre(wre_w[1]), .oute(oute_w[1]),
        .hb_mask(hb_w[1]), .lb_mask(lb_w[1]), .chip_en(ce_w[1])
    );

    // Asynchronous SRAM: drives data while selected and output-enabled.
    assign data0 = (!ce_w[0] && !oute_w[0] && wre_w[0]) ? mem[addr_w[0]] : 16'hzzzz;
    assign data1 = (!ce_w[1] && !oute_w[1] && wre_w[1]) ? mem[addr_w[1]] : 16'hzzzz;

    always @(posedge clock) begin
        if (!ce_w[0] && !wre_w[0]) begin
            if (!lb_w[0]) mem[addr_w[0]][7:0]  = data0[7:0];
            if (!hb_w[0]) mem[addr_w[0]][15:8] = data0[15:8];
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input int lane, input logic we, input logic [31:0] ba,
                           input logic [31:0] wd, input logic [3:0] be,
                           input bit keep, input bit from_done, input bit pulse, input string tag);
        int w, halves, exp_lat, ack_cyc, oute_n, wre_n, ce_n;
        int ovl, mask_bad, data_bad, busy_bad, post_bad;
        logic lo, hi, stb, prev_stb;
        logic [19:0] am, prev_am;
        logic [1:0] exp_m;
        logic [15:0] d;
        logic [17:0] a0, a1;
        logic [17:0] exp_q[$];
        logic [17:0] got_q[$];

        w = (lane == 0) ? 1 : 3;
        lo = we ? (be[1:0] != 2'b00) : 1'b1;
        hi = we ? (be[3:2] != 2'b00) : 1'b1;
        halves = int'(lo) + int'(hi);
        exp_lat = (halves == 0) ? 1 : halves * (w + 2) + 1;
        a0 = {ba[18:2], 1'b0};
        a1 = {ba[18:2], 1'b1};
        if (lo) exp_q.push_back(a0);
        if (hi) exp_q.push_back(a1);
        if (!we) exp_rd[lane] = {ref_mem[a1], ref_mem[a0]};
        ack_cyc = -1; oute_n = 0; wre_n = 0; ce_n = 0;
        ovl = 0; mask_bad = 0; data_bad = 0; busy_bad = 0; post_bad = 0;
        prev_stb = 1'b0; prev_am = '0;

        if (!from_done) @(negedge clock);
        req_w[lane] = 1'b1; we_w[lane] = we; ba_w[lane] = ba; wd_w[lane] = wd; be_w[lane] = be;
        if (from_done) begin
            @(posedge clock);
            @(negedge clock);
            chk_eq({tag, ":idle_busy"}, 32'(busy_w[lane]), 32'd0);
        end
        @(posedge clock);

        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            if (c == 1 && !keep) req_w[lane] = 1'b0;
            if (pulse && c == 3) begin req_w[lane] = 1'b1; ba_w[lane] = ba ^ 32'h40; end
            if (pulse && c == 4) req_w[lane] = 1'b0;
            stb = !wre_w[lane] || !oute_w[lane];
            am  = {addr_w[lane], hb_w[lane], lb_w[lane]};
            if (c > 1 && am != prev_am && (stb || prev_stb)) ovl++;
            if (!wre_w[lane] && !oute_w[lane]) ovl++;
            if (ack_cyc < 0) begin
                oute_n += int'(!oute_w[lane]);
                wre_n  += int'(!wre_w[lane]);
                ce_n   += int'(!ce_w[lane]);
                if (stb && !prev_stb) got_q.push_back(addr_w[lane]);
                if (stb) begin
                    exp_m = we ? ~(addr_w[lane][0] ? be[3:2] : be[1:0]) : 2'b00;
                    if ({hb_w[lane], lb_w[lane]} != exp_m) mask_bad++;
                end
                if (!wre_w[lane]) begin
                    d = (lane == 0) ? data0 : data1;
                    if (d != (addr_w[lane][0] ? wd[31:16] : wd[15:0])) data_bad++;
                end
                if (!busy_w[lane]) busy_bad++;
                if (ack_w[lane]) begin
                    ack_cyc = c;
                    chk_eq({tag, ":rdata"}, rdata_w[lane], exp_rd[lane]);
                    if (keep) break;
                end
            end else begin
                if (busy_w[lane] || ack_w[lane] || !ce_w[lane]) post_bad++;
                if (c >= ack_cyc + 4) break;
            end
            prev_stb = stb;
            prev_am  = am;
        end

        if (we) begin
            for (int h = 0; h < 2; h++) begin
                if (be[2*h])   ref_mem[{ba[18:2], h[0]}][7:0]  = wd[16*h +: 8];
                if (be[2*h+1]) ref_mem[{ba[18:2], h[0]}][15:8] = wd[16*h+8 +: 8];
            end
        end

        chk_eq({tag, ":latency"}, 32'(ack_cyc), 32'(exp_lat));
        chk_eq({tag, ":oute_cycles"}, 32'(oute_n), we ? 32'd0 : 32'(halves * w));
        chk_eq({tag, ":wre_cycles"}, 32'(wre_n), we ? 32'(halves * w) : 32'd0);
        chk_eq({tag, ":ce_cycles"}, 32'(ce_n), 32'(halves * (w + 2)));
        chk_eq({tag, ":bus_discipline"}, 32'(ovl), 32'd0);
        chk_eq({tag, ":masks"}, 32'(mask_bad), 32'd0);
        chk_eq({tag, ":wdata_bus"}, 32'(data_bad), 32'd0);
        chk_eq({tag, ":busy_window"}, 32'(busy_bad), 32'd0);
        chk_eq({tag, ":after_ack"}, 32'(post_bad), 32'd0);
        chk_eq({tag, ":n_access"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk_eq({tag, ":access_addr"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk_eq({tag, ":mem_lo"}, 32'(mem[a0]), 32'(ref_mem[a0]));
        chk_eq({tag, ":mem_hi"}, 32'(mem[a1]), 32'(ref_mem[a1]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] rba, rwd;
        logic [3:0]  rbe;
        logic        rwe;

        req_w = '0; we_w = '0; ba_w = '0; wd_w = '0; be_w = '0; exp_rd = '0;
        for (int i = 0; i < 262144; i++) begin
            mem[i]     = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        mem[8] = 16'h1234; ref_mem[8] = 16'h1234;
        mem[9] = 16'habcd; ref_mem[9] = 16'habcd;

        #3;
        chk_eq("reset_strobes", 32'({wre_w[0], oute_w[0], ce_w[0], hb_w[0], lb_w[0]}), 32'h1f);
        chk_eq("reset_addr", 32'(addr_w[0]), 32'd0);
        chk_eq("reset_ack_busy", 32'({ack_w[0], busy_w[0]}), 32'd0);
        chk_eq("reset_rdata", rdata_w[0], 32'd0);
        chk_eq("reset_lane1", 32'({wre_w[1], oute_w[1], ce_w[1], ack_w[1], busy_w[1]}), 32'h1c);
        #9 reset = 1'b1;

        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, "rd_basic");
        chk_eq("rd_basic_value", rdata_w[0], 32'habcd1234);
        run_txn(0, 1'b1, 32'h0000_0020, 32'hdead_beef, 4'hf, 0, 0, 0, "wr_full");
        chk_eq("wr_full_ram16", 32'(mem[16]), 32'h0000_beef);
        chk_eq("wr_full_ram17", 32'(mem[17]), 32'h0000_dead);
        run_txn(0, 1'b1, 32'h0000_0020, 32'h0077_0000, 4'b0100, 0, 0, 0, "wr_byte2");
        chk_eq("wr_byte2_ram17", 32'(mem[17]), 32'h0000_de77);
        run_txn(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0000, 0, 0, 0, "wr_none");
        run_txn(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 1, "rd_wait3");

        // Abort a write while its strobe is low.
        @(negedge clock);
        req_w[0] = 1'b1; we_w[0] = 1'b1; ba_w[0] = 32'h0000_0100; wd_w[0] = 32'h1111_2222; be_w[0] = 4'hf;
        @(posedge clock);
        @(negedge clock);
        req_w[0] = 1'b0;
        @(negedge clock);
        chk_eq("abort_pre_wre", 32'(wre_w[0]), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk_eq("abort_strobes", 32'({wre_w[0], oute_w[0], ce_w[0]}), 32'h7);
        chk_eq("abort_ack_busy", 32'({ack_w[0], busy_w[0]}), 32'd0);
        chk_eq("abort_rdata", rdata_w[0], 32'd0);
        exp_rd = '0;
        @(negedge clock);
        @(negedge clock);
        chk_eq("abort_no_ack", 32'({ack_w[0], ce_w[0]}), 32'h1);
        reset = 1'b1;
        chk_eq("abort_mem_lo", 32'(mem[128]), 32'(ref_mem[128]));
        chk_eq("abort_mem_hi", 32'(mem[129]), 32'(ref_mem[129]));
        run_txn(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, "rd_after_abort");

        run_txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1, 0, 0, "b2b_first");
        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1, 0, "b2b_second");

        for (int n = 0; n < 24; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rba = $urandom;
            rwd = $urandom;
            rbe = 4'($urandom_range(0, 15));
            run_txn(0, rwe, rba, rwd, rbe, 0, 0, 0, rwe ? "rand_wr" : "rand_rd");
        end
        for (int n = 0; n < 6; n++) begin
            rba = $urandom;
            run_txn(1, 1'b0, rba, 32'h0, 4'h0, 0, 0, 0, "rand_rd_w3");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
